// File: rtl/exe_w2_pkg.sv
// Shared types for the exe_w2 ZM/U2 arithmetic unit.
package exe_w2_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    SUB_ZM = 3'd0,
    ADD_ZM = 3'd1,
    ZM2U2  = 3'd2,
    U22ZM  = 3'd3,
    MUL_ZM = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_OVF = 2'b01,
    ST_NRP = 2'b10,
    ST_BAD = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/exe_w2_if.sv
// Request/response bundle between operand fetch and the exe_w2 unit.
interface exe_w2_if #(
  parameter int M = 8
);

  logic                          i_valid;
  logic [exe_w2_pkg::OP_W-1:0]   i_oper;
  logic [M-1:0]                  i_argA;
  logic [M-1:0]                  i_argB;
  logic                          o_ready;
  logic                          o_valid;
  logic [M-1:0]                  o_result;
  logic [1:0]                    o_status;

  modport slave (
    input  i_valid, i_oper, i_argA, i_argB,
    output o_ready, o_valid, o_result, o_status
  );

  modport master (
    output i_valid, i_oper, i_argA, i_argB,
    input  o_ready, o_valid, o_result, o_status
  );

endinterface

// File: rtl/exe_w2_mul_seq.sv
// Iterative shift-add multiplier for ZM magnitudes.
// One multiplier bit per cycle, M-1 cycles after start.
module exe_w2_mul_seq #(
  parameter int M = 8
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         start_i,
  input  logic [M-2:0] a_i,
  input  logic [M-2:0] b_i,
  output logic         done_o,
  output logic [M-2:0] product_o,
  output logic         ovf_o
);

  localparam int AW = 2*M-2;
  localparam int CW = $clog2(M);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] acc_q;
  logic [AW-1:0] mc_q;
  logic [M-2:0]  mp_q;

  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      mc_q   <= '0;
      mp_q   <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(M-1);
      acc_q  <= '0;
      mc_q   <= {{(M-1){1'b0}}, a_i};
      mp_q   <= b_i;
    end else if (busy_q) begin
      if (mp_q[0]) acc_q <= acc_q + mc_q;
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

  // done flags the edge that retires the last multiplier bit
  assign done_o    = busy_q && (cnt_q == CW'(1));
  assign product_o = acc_q[M-2:0];
  assign ovf_o     = |acc_q[AW-1:M-1];

endmodule

// File: rtl/exe_unit_w2.sv
// ZM / U2 arithmetic unit: add, sub, conversions, sequential multiply.
module exe_unit_w2
  import exe_w2_pkg::*;
#(
  parameter int M = 8,
  parameter int N = OP_W
) (
  input  logic    i_clk,
  input  logic    i_rsn,
  exe_w2_if.slave bus
);

  typedef struct packed {
    logic [1:0]   st;
    logic [M-1:0] res;
  } res_t;

  state_e       state_q, state_d;
  logic [N-1:0] op_q;
  logic [M-1:0] a_q, b_q, res_q;
  logic [1:0]   st_q;
  logic         vld_q;
  logic         accept, is_mul;
  logic         mul_done, mul_ovf;
  logic [M-2:0] mul_prod;
  res_t         r;

  function automatic res_t zm_pack(input logic sg, input logic [M-1:0] mag);
    res_t o;
    if (mag[M-1]) o = '{st: ST_OVF, res: '0};
    else          o = '{st: ST_OK, res: {sg && (|mag), mag[M-2:0]}};
    return o;
  endfunction

  function automatic res_t zm_addsub(input logic [M-1:0] a, b, input logic sub);
    logic sa, sb, sg;
    logic [M-1:0] ma, mb, mag;
    sa = a[M-1];
    sb = b[M-1] ^ sub;
    ma = {1'b0, a[M-2:0]};
    mb = {1'b0, b[M-2:0]};
    if (sa == sb) begin
      mag = ma + mb; sg = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sg = sa;
    end else begin
      mag = mb - ma; sg = sb;
    end
    return zm_pack(sg, mag);
  endfunction

  function automatic res_t zm2u2(input logic [M-1:0] a);
    logic [M-1:0] mag;
    mag = {1'b0, a[M-2:0]};
    return '{st: ST_OK, res: a[M-1] ? -mag : mag};
  endfunction

  function automatic res_t u22zm(input logic [M-1:0] a);
    logic [M-2:0] nm;
    nm = ~a[M-2:0] + 1'b1;
    if (a == {1'b1, {(M-1){1'b0}}}) return '{st: ST_NRP, res: '0};
    if (a[M-1]) return '{st: ST_OK, res: {1'b1, nm}};
    return '{st: ST_OK, res: a};
  endfunction

  assign accept = bus.i_valid && (state_q == IDLE);
  assign is_mul = bus.i_oper == MUL_ZM;

  exe_w2_mul_seq #(.M(M)) u_mul (
    .i_clk     (i_clk),
    .i_rsn     (i_rsn),
    .start_i   (accept && is_mul),
    .a_i       (bus.i_argA[M-2:0]),
    .b_i       (bus.i_argB[M-2:0]),
    .done_o    (mul_done),
    .product_o (mul_prod),
    .ovf_o     (mul_ovf)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_valid) state_d = is_mul ? MUL : EXEC;
      MUL:     if (mul_done) state_d = EXEC;
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r = '{st: ST_BAD, res: '0};
    unique case (1'b1)
      op_q == SUB_ZM: r = zm_addsub(a_q, b_q, 1'b1);
      op_q == ADD_ZM: r = zm_addsub(a_q, b_q, 1'b0);
      op_q == ZM2U2:  r = zm2u2(a_q);
      op_q == U22ZM:  r = u22zm(a_q);
      op_q == MUL_ZM: r = zm_pack(a_q[M-1] ^ b_q[M-1], {mul_ovf, mul_prod});
      default:        r = '{st: ST_BAD, res: '0};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      st_q    <= ST_OK;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= state_q == EXEC;
      if (accept) begin
        op_q <= bus.i_oper;
        a_q  <= bus.i_argA;
        b_q  <= bus.i_argB;
      end
      if (state_q == EXEC) begin
        res_q <= r.res;
        st_q  <= r.st;
      end
    end
  end

  assign bus.o_ready  = state_q == IDLE;
  assign bus.o_valid  = vld_q;
  assign bus.o_result = res_q;
  assign bus.o_status = st_q;

endmodule
